uart_tx_arbiter: RTL

- Shares one uart_tx transmitter among p_NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's word and drives the level send handshake into uart_tx.
- Tracks the frame through uart_tx o_active/o_done and returns per-requester grant and completion pulses.
- Sits between the system-side producers (command, status, debug streams) and the single uart_tx instance.

---
 rtl/uart_tx_arbiter_if.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signals of the round-robin UART transmit arbiter.
// master: the arbiter itself; slave: the surrounding requesters plus the uart_tx instance.
interface uart_tx_arbiter_if #(
    parameter int p_NUM_REQ  = 4,
    parameter int p_WORD_LEN = 8
);
    localparam int p_IDX_W = $clog2(p_NUM_REQ);
    localparam int p_W     = p_WORD_LEN + 1;

    logic [p_NUM_REQ-1:0]       i_req;
    logic [p_NUM_REQ*p_W-1:0]   i_data;
    logic [p_NUM_REQ-1:0]       o_grant;
    logic [p_NUM_REQ-1:0]       o_cmpl;
    logic [p_NUM_REQ-1:0]       o_err;
    logic                       o_busy;
    logic [p_IDX_W-1:0]         o_owner;
    logic                       o_tx_send;
    logic [p_W-1:0]             o_tx_data;
    logic                       i_tx_active;
    logic                       i_tx_done;

    modport master (
        input  i_req, i_data, i_tx_active, i_tx_done,
        output o_grant, o_cmpl, o_err, o_busy, o_owner, o_tx_send, o_tx_data
    );

    modport slave (
        output i_req, i_data, i_tx_active, i_tx_done,
        input  o_grant, o_cmpl, o_err, o_busy, o_owner, o_tx_send, o_tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among p_NUM_REQ requesters: capture the winner's word,
// drive the level send handshake, and report grant / completion / timeout pulses per requester.
module uart_tx_arbiter #(
    parameter int p_NUM_REQ  = 4,
    parameter int p_WORD_LEN = 8,
    parameter int p_TIMEOUT  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    uart_tx_arbiter_if.master bus
);
    localparam int p_IDX_W = $clog2(p_NUM_REQ);
    localparam int p_W     = p_WORD_LEN + 1;
    localparam int p_CNT_W = $clog2(p_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_DRAIN
    } state_e;

    state_e               state_q, state_d;
    logic [p_IDX_W-1:0]   last_q, last_d;
    logic [p_IDX_W-1:0]   owner_q, owner_d;
    logic [p_W-1:0]       data_q, data_d;
    logic [p_CNT_W-1:0]   cnt_q, cnt_d;
    logic [p_NUM_REQ-1:0] grant_q, grant_d;
    logic [p_NUM_REQ-1:0] cmpl_q, cmpl_d;
    logic [p_NUM_REQ-1:0] err_q, err_d;

    logic [2*p_NUM_REQ-1:0] req_rot;
    logic                   win_vld;
    logic [p_IDX_W-1:0]     win_idx;
    logic                   tx_idle;

    function automatic logic [p_NUM_REQ-1:0] onehot(input logic [p_IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    assign tx_idle = !bus.i_tx_active && !bus.i_tx_done;

    // Rotate the request vector so bit 0 is the requester just after the last owner.
    always_comb begin
        req_rot = {bus.i_req, bus.i_req} >> (int'(last_q) + 1);
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = 0; i < p_NUM_REQ; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_vld = 1'b1;
                win_idx = p_IDX_W'((int'(last_q) + 1 + i) % p_NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        owner_d = owner_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        cmpl_d  = '0;
        err_d   = '0;
        case (state_q)
            S_IDLE: begin
                // A uart_tx still finishing a frame from before reset keeps us here.
                if (win_vld && tx_idle) begin
                    data_d  = bus.i_data[int'(win_idx)*p_W +: p_W];
                    last_d  = win_idx;
                    owner_d = win_idx;
                    grant_d = onehot(win_idx);
                    cnt_d   = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.i_tx_active) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == p_CNT_W'(p_TIMEOUT - 1)) begin
                    err_d   = onehot(owner_q);
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + p_CNT_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (bus.i_tx_done) begin
                    cmpl_d  = onehot(owner_q);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // o_done lasts two cycles; wait it out so a frame yields a single o_cmpl.
                if (tx_idle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            last_q  <= p_IDX_W'(p_NUM_REQ - 1);
            owner_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            cmpl_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            cmpl_q  <= cmpl_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_grant   = grant_q;
    assign bus.o_cmpl    = cmpl_q;
    assign bus.o_err     = err_q;
    assign bus.o_owner   = owner_q;
    assign bus.o_tx_data = data_q;
    assign bus.o_busy    = (state_q != S_IDLE);
    assign bus.o_tx_send = (state_q == S_ISSUE);
endmodule
